// File: rtl/program_sequencer_pkg.sv
// Shared encodings and instruction layout for the RPN CPU fetch stage.
// Imported by the sequencer, its attention latch and the bench.
package program_sequencer_pkg;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_MOV = 3'd1;
  localparam logic [2:0] CMD_ACC = 3'd2;
  localparam logic [2:0] CMD_JMP = 3'd3;
  localparam logic [2:0] CMD_ATC = 3'd4;

  localparam logic [2:0] COND_UNC = 3'd0;
  localparam logic [2:0] COND_EQ  = 3'd1;
  localparam logic [2:0] COND_NEQ = 3'd2;
  localparam logic [2:0] COND_SLT = 3'd3;
  localparam logic [2:0] COND_SLE = 3'd4;
  localparam logic [2:0] COND_SGT = 3'd5;
  localparam logic [2:0] COND_SGE = 3'd6;

  localparam logic [2:0] ATC_PUSH = 3'd0;
  localparam logic [2:0] ATC_OFLW = 3'd7;

  localparam logic TYPE_NUM = 1'b0;
  localparam logic TYPE_REG = 1'b1;

  typedef struct packed {
    logic [2:0] cmd;
    logic [2:0] sel;
    logic       type1;
    logic [7:0] arg1;
    logic       type2;
    logic [7:0] arg2;
    logic [7:0] target;
  } instr_t;

  function automatic logic [7:0] onehot(
    input logic [2:0] k
  );
    return 8'b1 << k;
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Fetch/operand bus between the sequencer, instruction memory
// and the register file read ports.
interface program_sequencer_if;

  logic [31:0] instruction;
  logic [7:0]  address;
  logic [7:0]  rd_addr1;
  logic [7:0]  rd_addr2;
  logic [7:0]  rd_data1;
  logic [7:0]  rd_data2;

  modport master (
    input  instruction,
    input  rd_data1,
    input  rd_data2,
    output address,
    output rd_addr1,
    output rd_addr2
  );

  modport slave (
    output instruction,
    output rd_data1,
    output rd_data2,
    input  address,
    input  rd_addr1,
    input  rd_addr2
  );

endinterface

// File: rtl/attention_latch.sv
// Edge-detect and set/consume latch for button attention events;
// LEVEL_MASK bits bypass the latch and report the live input.
module attention_latch
  import program_sequencer_pkg::*;
#(
  parameter logic [7:0] LEVEL_MASK = 8'b1 << ATC_OFLW
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] atc_in,
  input  logic [7:0] consume,
  output logic [7:0] pending,
  output logic [7:0] latch
);

  logic [7:0] prev;
  logic [7:0] held;
  logic [7:0] edges;

  assign edges   = atc_in & ~prev & ~LEVEL_MASK;
  assign pending = ((held | edges) & ~LEVEL_MASK)
                 | (atc_in & LEVEL_MASK);
  assign latch   = held;

  // prev loads from atc_in on reset so a held button raises no event
  always_ff @(posedge clock) begin
    if (reset) begin
      held <= '0;
      prev <= atc_in;
    end else if (enable) begin
      held <= (held & ~consume) | edges;
      prev <= atc_in;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch stage: owns the PC and resolves JMP / ATC branches
// for the word currently returned by instruction memory.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter logic [7:0] RESET_ADDR = 8'd0,
  parameter logic [7:0] LEVEL_MASK = 8'b1 << ATC_OFLW
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] atc_in,
  program_sequencer_if.master bus,
  output logic       jump_taken,
  output logic [7:0] atc_pending
);

  instr_t     ins;
  logic [7:0] pc;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] pending;
  logic [7:0] consume;
  logic       cond_hit;
  logic       is_jmp;
  logic       is_atc;

  assign ins          = bus.instruction;
  assign bus.rd_addr1 = ins.arg1;
  assign bus.rd_addr2 = ins.arg2;
  assign bus.address  = pc;

  assign op_a = (ins.type1 == TYPE_REG) ? bus.rd_data1 : ins.arg1;
  assign op_b = (ins.type2 == TYPE_REG) ? bus.rd_data2 : ins.arg2;

  assign is_jmp = (ins.cmd == CMD_JMP);
  assign is_atc = (ins.cmd == CMD_ATC);

  always_comb begin
    cond_hit = 1'b0;
    case (ins.sel)
      COND_UNC: cond_hit = 1'b1;
      COND_EQ:  cond_hit = (op_a == op_b);
      COND_NEQ: cond_hit = (op_a != op_b);
      COND_SLT: cond_hit = ($signed(op_a) <  $signed(op_b));
      COND_SLE: cond_hit = ($signed(op_a) <= $signed(op_b));
      COND_SGT: cond_hit = ($signed(op_a) >  $signed(op_b));
      COND_SGE: cond_hit = ($signed(op_a) >= $signed(op_b));
      default:  cond_hit = 1'b0;
    endcase
  end

  // level bits are never consumed; they track the live source
  always_comb begin
    jump_taken = 1'b0;
    consume    = '0;
    unique case (1'b1)
      is_jmp: jump_taken = cond_hit;
      is_atc: begin
        jump_taken = pending[ins.sel];
        if (jump_taken && !LEVEL_MASK[ins.sel])
          consume = onehot(ins.sel);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      pc <= RESET_ADDR;
    else if (enable)
      pc <= jump_taken ? ins.target : pc + 8'd1;
  end

  attention_latch #(
    .LEVEL_MASK (LEVEL_MASK)
  ) u_attn (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .atc_in  (atc_in),
    .consume (consume),
    .pending (pending),
    .latch   (atc_pending)
  );

endmodule
